sub_pipe_param: RTL and testbench
=================================

Name: sub_pipe_param

Overview:
- Parametrised, pipelined unsigned/two's-complement subtractor. Successor to the fixed 8-bit combinational subtract/decrement macro.
- Operand width is generic. The borrow chain is split into CHUNK-bit slices, with one register stage per slice.
- Adds a valid/ready handshake, borrow-in, a decrement mode, and borrow and signed-overflow flags.
- Sits in the datapath library and is used by counters and address/offset arithmetic that need a registered difference at high clock rates.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CHUNK, 4, bits resolved per pipeline stage (1..WIDTH). Number of stages S = ceil(WIDTH/CHUNK).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend; ignored when mode=1.
- bin  input  1  borrow-in; ignored when mode=1.
- mode  input  1  0: a−b−bin; 1: decrement, a−1.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  difference, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 iff unsigned a < b+bin (mode 0) or a==0 (mode 1).
- ovf  output  1  signed overflow: sign(a)≠sign(b_eff) and sign(diff)≠sign(a).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits clear; out_valid=0; diff=0, bout=0, ovf=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Effective operands are taken at acceptance:
  - mode=1: b_eff=1, bin_eff=0.
  - mode=0: b_eff=b, bin_eff=bin.
- Stage k (0..S−1) computes diff bits [k*CHUNK +: CHUNK] from the registered operand slice and the registered borrow of stage k−1. Stage 0 uses bin_eff. The last slice may be narrower than CHUNK when WIDTH is not a multiple.
- Upper operand slices travel skewed alongside, so each slice meets its borrow in the correct cycle.
- Latency:
  - A beat accepted at edge N presents out_valid=1 with its result after edge N+S, absent stalls.
  - With CHUNK=WIDTH, S=1, which is a single registered stage.
- Handshake:
  - A beat is accepted when in_valid & in_ready. A result transfers when out_valid & out_ready.
  - adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=0 the whole pipeline holds: every stage register, valid bit and output stays constant.
  - When adv=1 all stages shift by one. An empty input slot injects a bubble (valid=0).
  - No combinational path from in_valid to out_valid. in_ready depends only on out_valid and out_ready.
- Throughput is one beat per cycle while out_ready=1. Bubbles are not collapsed.
- Simultaneous accept and transfer in the same cycle is legal and keeps full throughput.
- Results leave in acceptance order. The data outputs diff, bout and ovf hold their last value while out_valid=0.
- Wrap-around: diff is always modulo 2^WIDTH. Example: 0x00−0x01 → 0xFF, bout=1.

Optional Feature:
- SUB_PIPE_SAT_EN
  - Defined: unsigned saturation at the output stage. When bout=1, diff is forced to 0. bout and ovf are still reported unchanged.
  - Not defined: diff is the plain modular result.
  - Latency and handshake are identical in both builds.

Test Plan:
- Defaults (WIDTH=8, CHUNK=4, S=2):
  - Stimulus: a=0x5A, b=0x3C, bin=0, mode=0, accepted at edge 0, out_ready=1.
  - Response: out_valid=1 after edge 2 with diff=0x1E, bout=0, ovf=0.
- Borrow across the slice boundary:
  - Stimulus: a=0x10, b=0x01, bin=1.
  - Response: diff=0x0E, bout=0. Then a=0x00, mode=1 gives diff=0xFF, bout=1; with SUB_PIPE_SAT_EN defined it gives diff=0x00, bout=1.
- Signed overflow:
  - Case 1: a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0.
  - Case 2: a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
- Back-pressure:
  - Stimulus: stream 4 beats on consecutive cycles; hold out_ready=0 for 3 cycles after the first result appears.
  - Response: in_ready=0 and diff/out_valid are stable for those cycles; all 4 results arrive in order and none are lost or duplicated.
- Reset mid-flight:
  - Stimulus: accept 2 beats, then assert rst for 1 cycle.
  - Response: out_valid=0, diff=0, in_ready=1 next cycle; the discarded beats never appear.
- Parameter sweep:
  - Stimulus: WIDTH=13, CHUNK=5 (S=3) and WIDTH=8, CHUNK=8 (S=1), random operands, random out_ready.
  - Response: every result matches the reference model a−b−bin mod 2^WIDTH plus flags; latency is S cycles when there is no stall.

Source files
------------

// File: rtl/sub_pipe_param.sv
// sub_pipe_param -- pipelined subtractor / decrementer with valid/ready handshake.
//
// Computes a - b - bin (mode=0) or a - 1 (mode=1) modulo 2^WIDTH. The borrow
// chain is resolved CHUNK bits per stage, S = ceil(WIDTH/CHUNK) stages.
// An accepted beat is registered into stage 0 and the result is presented S
// cycles later on the output registers.
//
// Optional build macro: SUB_PIPE_SAT_EN -- when defined, diff is clamped to 0
// whenever bout=1 (unsigned saturation). bout/ovf, latency and handshake are
// unaffected.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle
//   a, b       minuend / subtrahend (b ignored when mode=1)
//   bin        borrow-in (ignored when mode=1)
//   mode       0: a-b-bin, 1: a-1
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   diff       difference mod 2^WIDTH
//   bout       unsigned borrow-out
//   ovf        two's-complement overflow
module sub_pipe_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned S = (WIDTH + CHUNK - 1) / CHUNK;

  // Stage k holds: operands (full width; only slice k and the MSBs are still
  // consumed downstream), the diff bits already resolved below slice k, and
  // the borrow into slice k.
  logic [WIDTH-1:0] a_q [S];
  logic [WIDTH-1:0] b_q [S];
  logic [WIDTH-1:0] d_q [S];
  logic [S-1:0]     br_q;
  logic [S-1:0]     vld_q;

  // Per-stage combinational result: diff with slice k filled in, borrow out.
  logic [WIDTH-1:0] nd [S];
  logic [S-1:0]     nb;

  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             adv;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;
  logic             ovf_d;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < S; k++) begin : g_slice
    localparam int unsigned LO = k * CHUNK;
    // Last slice is narrower when WIDTH is not a multiple of CHUNK.
    localparam int unsigned W  = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;
    localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - W)) << LO;

    // One extra bit on the left: it ends up set exactly when the slice borrows.
    logic [W:0] t;
    assign t     = {1'b0, a_q[k][LO +: W]} - {1'b0, b_q[k][LO +: W]} - (W+1)'(br_q[k]);
    assign nd[k] = (d_q[k] & ~MASK) | (WIDTH'(t[W-1:0]) << LO);
    assign nb[k] = t[W];
  end

  assign bout_d = nb[S-1];
  assign ovf_d  = (a_q[S-1][WIDTH-1] ^ b_q[S-1][WIDTH-1]) &
                  (nd[S-1][WIDTH-1] ^ a_q[S-1][WIDTH-1]);

`ifdef SUB_PIPE_SAT_EN
  assign diff_d = bout_d ? '0 : nd[S-1];
`else
  assign diff_d = nd[S-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      br_q        <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      // Effective operands fixed here; decrement is a - 1 with no borrow-in.
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= mode ? WIDTH'(1) : b;
      br_q[0]  <= ~mode & bin;
      d_q[0]   <= '0;
      for (int unsigned k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        d_q[k]   <= nd[k-1];
        br_q[k]  <= nb[k-1];
      end
      out_valid_q <= vld_q[S-1];
      // Data outputs only change on a real result so they hold across bubbles.
      if (vld_q[S-1]) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_pipe_param.sv
// Testbench for sub_pipe_param: directed vectors on the default (8/4) build,
// plus 13/5 and 8/8 instances exercised with random operands and out_ready.
module tb_sub_pipe_param;

`ifdef SUB_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: WIDTH=8, CHUNK=4 (S=2)
  logic       a_iv, a_ir, a_ov, a_or, a_bin, a_mode, a_bout, a_ovf;
  logic [7:0] a_a, a_b, a_diff;
  // Instance B: WIDTH=13, CHUNK=5 (S=3)
  logic        b_iv, b_ir, b_ov, b_or, b_bin, b_mode, b_bout, b_ovf;
  logic [12:0] b_a, b_b, b_diff;
  // Instance C: WIDTH=8, CHUNK=8 (S=1)
  logic       c_iv, c_ir, c_ov, c_or, c_bin, c_mode, c_bout, c_ovf;
  logic [7:0] c_a, c_b, c_diff;

  sub_pipe_param #(.WIDTH(8), .CHUNK(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .a(a_a), .b(a_b),
    .bin(a_bin), .mode(a_mode), .out_valid(a_ov), .out_ready(a_or),
    .diff(a_diff), .bout(a_bout), .ovf(a_ovf));

  sub_pipe_param #(.WIDTH(13), .CHUNK(5)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .a(b_a), .b(b_b),
    .bin(b_bin), .mode(b_mode), .out_valid(b_ov), .out_ready(b_or),
    .diff(b_diff), .bout(b_bout), .ovf(b_ovf));

  sub_pipe_param #(.WIDTH(8), .CHUNK(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .a(c_a), .b(c_b),
    .bin(c_bin), .mode(c_mode), .out_valid(c_ov), .out_ready(c_or),
    .diff(c_diff), .bout(c_bout), .ovf(c_ovf));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: packs {ovf, bout, diff[w-1:0]}.
  function automatic logic [31:0] ref_sub(input int unsigned w, input logic [31:0] a,
                                          input logic [31:0] b, input logic bin,
                                          input logic mode);
    logic [31:0] be, msk, d;
    logic        bi, bo, ov;
    be  = mode ? 32'd1 : b;
    bi  = mode ? 1'b0 : bin;
    msk = (32'd1 << w) - 32'd1;
    d   = (a - be - {31'd0, bi}) & msk;
    bo  = ({1'b0, a} < ({1'b0, be} + {32'd0, bi}));
    ov  = (a[w-1] != be[w-1]) && (d[w-1] != a[w-1]);
    if (SAT && bo) d = '0;
    return ({30'd0, ov, bo} << w) | d;
  endfunction

  // One beat through instance A with fixed 2-cycle latency check.
  task automatic run_a(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic tmode,
                       input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    a_a = ta; a_b = tb; a_bin = tbin; a_mode = tmode; a_iv = 1'b1; a_or = 1'b1;
    #1 check({tag, "/in_ready"}, 32'(a_ir), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_iv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/early_valid"}, 32'(a_ov), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "/valid"}, 32'(a_ov), 32'd1);
    check(tag, 32'({a_ovf, a_bout, a_diff}), 32'({eo, eb, ed}));
  endtask

  logic [31:0] qb[$];
  logic [31:0] qc[$];
  logic [7:0]  bp_exp [4];
  int unsigned got_n, lat_b, lat_c, vcnt;

  initial begin
    rst = 1'b1;
    a_iv = 0; a_or = 0; a_a = '0; a_b = '0; a_bin = 0; a_mode = 0;
    b_iv = 0; b_or = 0; b_a = '0; b_b = '0; b_bin = 0; b_mode = 0;
    c_iv = 0; c_or = 0; c_a = '0; c_b = '0; c_bin = 0; c_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/out_valid", 32'(a_ov), 32'd0);
    check("rst/data", 32'({a_ovf, a_bout, a_diff}), 32'd0);
    check("rst/in_ready", 32'(a_ir), 32'd1);
    check("rst/b_valid", 32'(b_ov), 32'd0);
    check("rst/c_valid", 32'(c_ov), 32'd0);
    rst = 1'b0;

    // Directed vectors, hand-computed
    run_a("basic",      8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_a("slice_brw",  8'h10, 8'h01, 1'b1, 1'b0, 8'h0E, 1'b0, 1'b0);
    run_a("dec_zero",   8'h00, 8'h00, 1'b0, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0);
    run_a("ovf_neg",    8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_a("ovf_pos",    8'h7F, 8'hFF, 1'b0, 1'b0, SAT ? 8'h00 : 8'h80, 1'b1, 1'b1);
    run_a("dec_ign_b",  8'h80, 8'h55, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_a("bin_wrap",   8'h00, 8'h00, 1'b1, 1'b0, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0);

    // Back-pressure: 4 beats, stall 3 cycles once the first result shows
    bp_exp[0] = 8'h1F; bp_exp[1] = 8'h2E; bp_exp[2] = 8'h3D; bp_exp[3] = 8'h4C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_a = 8'h20 + 8'(i) * 8'h10; a_b = 8'(i + 1); a_bin = 0; a_mode = 0;
      a_iv = 1'b1; a_or = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("bp/first_valid", 32'(a_ov), 32'd1);
    a_or = 1'b0;
    a_a = 8'h50; a_b = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp/in_ready_low", 32'(a_ir), 32'd0);
      check("bp/hold", 32'({a_ov, a_diff}), 32'({1'b1, 8'h1F}));
    end
    a_or = 1'b1;
    got_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 1) a_iv = 1'b0;
      if (a_ov) begin
        if (got_n < 4) check("bp/order", 32'(a_diff), 32'(bp_exp[got_n]));
        got_n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("bp/count", got_n, 32'd4);

    // Reset mid-flight
    @(negedge clk);
    a_a = 8'h33; a_b = 8'h11; a_iv = 1'b1; a_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_a = 8'h44;
    @(posedge clk);
    @(negedge clk);
    a_iv = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst/out_valid", 32'(a_ov), 32'd0);
    check("midrst/diff", 32'(a_diff), 32'd0);
    check("midrst/in_ready", 32'(a_ir), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ov) vcnt++;
    end
    check("midrst/ghost", vcnt, 32'd0);

    // Latency of the swept configurations, no stall
    @(negedge clk);
    b_a = 13'h1000; b_b = 13'h0001; b_bin = 0; b_mode = 0; b_iv = 1; b_or = 1;
    c_a = 8'h00; c_b = 8'h00; c_bin = 1; c_mode = 0; c_iv = 1; c_or = 1;
    @(posedge clk);
    @(negedge clk);
    b_iv = 0; c_iv = 0;
    lat_b = 0; lat_c = 0;
    for (int unsigned c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_ov && lat_b == 0) begin
        lat_b = c;
        check("w13/lat_val", 32'({b_ovf, b_bout, b_diff}), 32'h4FFF);
      end
      if (c_ov && lat_c == 0) begin
        lat_c = c;
        check("w8s1/lat_val", 32'({c_ovf, c_bout, c_diff}), SAT ? 32'h100 : 32'h1FF);
      end
    end
    check("w13/latency", lat_b, 32'd3);
    check("w8s1/latency", lat_c, 32'd1);

    // Random sweep with random back-pressure, then drain
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      if (cyc < 300) begin
        b_iv = 1'($urandom); b_or = ($urandom_range(3) != 0);
        b_a = 13'($urandom); b_b = 13'($urandom); b_bin = 1'($urandom);
        b_mode = ($urandom_range(3) == 0);
        c_iv = 1'($urandom); c_or = ($urandom_range(3) != 0);
        c_a = 8'($urandom); c_b = 8'($urandom); c_bin = 1'($urandom);
        c_mode = ($urandom_range(3) == 0);
      end else begin
        b_iv = 0; b_or = 1; c_iv = 0; c_or = 1;
      end
      #1;
      if (b_ov && b_or) begin
        if (qb.size() == 0) check("w13/extra", 32'd1, 32'd0);
        else check("w13/rand", 32'({b_ovf, b_bout, b_diff}), qb.pop_front());
      end
      if (b_iv && b_ir) qb.push_back(ref_sub(13, 32'(b_a), 32'(b_b), b_bin, b_mode));
      if (c_ov && c_or) begin
        if (qc.size() == 0) check("w8s1/extra", 32'd1, 32'd0);
        else check("w8s1/rand", 32'({c_ovf, c_bout, c_diff}), qc.pop_front());
      end
      if (c_iv && c_ir) qc.push_back(ref_sub(8, 32'(c_a), 32'(c_b), c_bin, c_mode));
    end
    check("w13/lost", qb.size(), 32'd0);
    check("w8s1/lost", qc.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
